mu0_mem_responder: RTL and testbench
====================================

# mu0_mem_responder

Memory-side responder for the MU0 CPU. It accepts one read or write request at a time from the CPU's fetch/exec sequencer over a valid/ready request channel. It holds a word-addressed 2^ADDR_W x DATA_W RAM and returns each result on a valid/ready response channel after a fixed, parameterised number of wait states. It is the far end of the CPU's memory interface: the CPU issues instruction fetches and operand accesses, and this block answers them.

## Interface
- ADDR_W, default 12: word address width (MU0 12-bit address field).
- DATA_W, default 16: data word width.
- WAIT_CYCLES, default 1: wait states between acceptance and access; legal range 0..15.
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  reset; asynchronous, active-low.
- req_valid  input  1  CPU presents a request.
- req_ready  output  1  responder can accept a request (registered).
- req_we  input  1  1 = write, 0 = read; sampled on acceptance.
- req_addr  input  ADDR_W  word address; sampled on acceptance.
- req_wdata  input  DATA_W  write data; sampled on acceptance.
- rsp_valid  output  1  response available (registered).
- rsp_ready  input  1  CPU consumes the response.
- rsp_rdata  output  DATA_W  read data, or echoed write data for writes (registered).
- busy  output  1  high in WAIT or RESP.

## Operation
- States: IDLE, WAIT, RESP. A 4-bit down-counter `cnt` drives the wait states.
- **IDLE**
  - Acceptance occurs when req_valid && req_ready at a rising edge.
  - On acceptance, latch req_we, req_addr and req_wdata.
  - If WAIT_CYCLES==0: perform the access at this same edge and go to RESP.
  - Otherwise: load cnt=WAIT_CYCLES and go to WAIT.
- **WAIT**
  - Each edge decrements cnt.
  - At the edge where cnt==1: perform the access and go to RESP.
  - req_valid is ignored in this state.
- **Access (one edge only)**
  - Write: store latched wdata at the latched address; rsp_rdata := latched wdata.
  - Read: rsp_rdata := mem[latched address].
- **RESP**
  - rsp_valid=1; rsp_rdata is held stable until rsp_valid && rsp_ready at an edge.
  - On that handshake, go to IDLE.
- req_ready is registered: req_ready = (next state == IDLE). It is therefore 0 from the acceptance edge until the response-handshake edge. Only one request is ever outstanding; there is no pipelining.
- busy = (state != IDLE), decoded from the state register.
- RAM contents are not reset. A read of a never-written location returns undefined data.
- Every ADDR_W-bit address is valid (full decode); there is no error response.
- A request held on req_valid while req_ready=0 is not accepted. The CPU must keep it stable until acceptance.

## Timing
- **Reset (rst_n low, asynchronous):** state=IDLE, cnt=0, req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0.
- **First edge with rst_n high:** req_ready becomes 1. No request can be accepted at that edge.
- **Latency:** with acceptance at edge E, the access occurs at edge E+WAIT_CYCLES, and rsp_valid is high from edge E+WAIT_CYCLES onward.
  - WAIT_CYCLES=0: rsp_valid is high in the cycle after acceptance.
  - WAIT_CYCLES=1: one cycle in WAIT, then RESP.
- **Back-to-back:** on the response-handshake edge, req_ready rises. The next acceptance is at the following edge or later. Minimum request spacing is WAIT_CYCLES+2 edges when rsp_ready is held high.
- **Simultaneous events:** req_valid asserted during WAIT/RESP has no effect. rsp_ready asserted while rsp_valid=0 has no effect.
- **Backpressure:** rsp_ready low holds RESP, rsp_valid and rsp_rdata indefinitely. The RAM is not modified while holding.
- **Reset mid-operation:**
  - The FSM returns to IDLE and rsp_valid drops immediately.
  - A write whose commit edge has not occurred is discarded; RAM is unchanged.
  - A write already committed is kept.

## Test plan
- **Reset:** assert rst_n=0 mid-cycle -> all outputs 0 asynchronously. Release -> req_ready=1 exactly one edge later.
- **Write then read, WAIT_CYCLES=1:**
  - Write 0xBEEF to 0x0A5 -> rsp_valid rises 1 edge after acceptance, with rsp_rdata=0xBEEF.
  - Read 0x0A5 -> rsp_rdata=0xBEEF. busy is high from acceptance to the handshake.
- **Zero wait, WAIT_CYCLES=0:** write 0x1234 to 0xFFF, then read 0xFFF -> each rsp_valid is high in the cycle after acceptance. Read returns 0x1234 (tests address wrap at the top).
- **Backpressure:**
  - Read with rsp_ready=0 for 5 cycles -> rsp_valid stays 1 with rsp_rdata stable and req_ready=0.
  - A second req_valid issued meanwhile is not accepted.
  - Raise rsp_ready -> handshake, then req_ready=1 on the next edge.
- **Reset mid-write, WAIT_CYCLES=3:**
  - Write 0x5555 to 0x010 (previously 0x0000), then pulse rst_n low 1 cycle after acceptance -> subsequent read of 0x010 returns 0x0000.
  - Repeat with the pulse after the commit edge -> read returns 0x5555.
- **Throughput:** WAIT_CYCLES=2, rsp_ready tied high, req_valid held high for 4 reads -> acceptances spaced exactly 4 edges apart and all data correct.

Source files
------------

// File: rtl/mu0_mem_responder.sv
`timescale 1ns/1ps
// mu0_mem_responder
// Memory-side responder for the MU0 CPU. It accepts one read or write request
// at a time and holds a word-addressed 2^ADDR_W x DATA_W RAM. Each result is
// returned WAIT_CYCLES edges after acceptance, on a valid/ready response channel.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  responder can accept a request (registered)
//   req_we     1 = write, 0 = read (sampled on acceptance)
//   req_addr   word address (sampled on acceptance)
//   req_wdata  write data (sampled on acceptance)
//   rsp_valid  response available (registered)
//   rsp_ready  response consumed
//   rsp_rdata  read data, or echoed write data for writes (registered)
//   busy       high while in WAIT or RESP
module mu0_mem_responder #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LD   = 4'(WAIT_CYCLES);
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                do_access;
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic                mem_we;

  // req_ready_q is only ever high in IDLE, but the state term keeps the intent explicit
  assign accept = (state_q == S_IDLE) && req_valid && req_ready_q;

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = ZERO_WAIT ? S_RESP : S_WAIT;
      S_WAIT: if (cnt_q == 4'd1) state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;

    if (accept) begin
      we_d    = req_we;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      cnt_d   = WAIT_LD;
    end
    if (state_q == S_WAIT) cnt_d = cnt_q - 4'd1;

    // With zero wait states the access happens on the acceptance edge itself,
    // so the request inputs feed the RAM directly instead of the latched copy.
    do_access = (accept && ZERO_WAIT) || ((state_q == S_WAIT) && (cnt_q == 4'd1));
    acc_we    = (state_q == S_IDLE) ? req_we    : we_q;
    acc_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    acc_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    mem_we    = do_access && acc_we;

    if (do_access) rsp_rdata_d = acc_we ? acc_wdata : mem[acc_addr];

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  // RAM has no reset. A reset forces IDLE, so an uncommitted write never reaches it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_addr] <= acc_wdata;
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mu0_mem_responder.sv
`timescale 1ns/1ps
// Testbench for mu0_mem_responder: four instances with WAIT_CYCLES = 0..3
// (instance index equals its wait-state count).
module tb_mu0_mem_responder;

  localparam int NDUT = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [NDUT];
  logic        req_valid [NDUT];
  logic        req_ready [NDUT];
  logic        req_we    [NDUT];
  logic [11:0] req_addr  [NDUT];
  logic [15:0] req_wdata [NDUT];
  logic        rsp_valid [NDUT];
  logic        rsp_ready [NDUT];
  logic [15:0] rsp_rdata [NDUT];
  logic        busy      [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mu0_mem_responder #(
      .ADDR_W(12), .DATA_W(16), .WAIT_CYCLES(g)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .busy      (busy[g])
    );
  end

  typedef struct {
    int          dut;
    bit          we;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [16];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for req_ready, presents a request and returns #1 after the acceptance edge.
  task automatic issue(input int d, input bit we, input logic [11:0] a,
                       input logic [15:0] wd, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (req_ready[d] === 1'b1);
    if (!ok) begin
      chk($sformatf("issue_ready_timeout_dut%0d", d), 32'(req_ready[d]), 32'd1);
      return;
    end
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
  endtask

  // Called #1 after an edge; returns #1 after the first edge with rsp_valid high.
  task automatic wait_rsp(input int d, output int lat, output bit ok);
    lat = 0;
    while (rsp_valid[d] !== 1'b1 && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    ok = (rsp_valid[d] === 1'b1);
    if (!ok) chk($sformatf("rsp_timeout_dut%0d", d), 32'(rsp_valid[d]), 32'd1);
  endtask

  // Full transaction with rsp_ready held high.
  task automatic txn(input int d, input bit we, input logic [11:0] a,
                     input logic [15:0] wd, input logic [15:0] exp, input string tag);
    bit ok;
    int lat;
    rsp_ready[d] = 1'b1;
    issue(d, we, a, wd, ok);
    if (!ok) return;
    chk({tag, "_busy_at_accept"}, 32'(busy[d]), 32'd1);
    chk({tag, "_ready_at_accept"}, 32'(req_ready[d]), 32'd0);
    wait_rsp(d, lat, ok);
    if (!ok) return;
    chk({tag, "_latency"}, 32'(lat), 32'(d));
    chk({tag, "_rdata"}, 32'(rsp_rdata[d]), 32'(exp));
    @(posedge clk);
    #1;
    chk({tag, "_valid_after_hs"}, 32'(rsp_valid[d]), 32'd0);
    chk({tag, "_ready_after_hs"}, 32'(req_ready[d]), 32'd1);
    chk({tag, "_busy_after_hs"}, 32'(busy[d]), 32'd0);
  endtask

  logic [11:0] tp_addr [4];
  logic [15:0] tp_data [4];
  int          acc_e   [4];
  int          nacc, nrsp, edge_n, lat_v;
  bit          rr, ok_v;

  initial begin
    vecs[0]  = '{1, 1'b1, 12'h0A5, 16'hBEEF, 16'hBEEF};
    vecs[1]  = '{1, 1'b0, 12'h0A5, 16'h0000, 16'hBEEF};
    vecs[2]  = '{1, 1'b1, 12'h000, 16'h0001, 16'h0001};
    vecs[3]  = '{1, 1'b1, 12'h001, 16'hA5A5, 16'hA5A5};
    vecs[4]  = '{1, 1'b0, 12'h000, 16'h0000, 16'h0001};
    vecs[5]  = '{1, 1'b0, 12'h001, 16'h0000, 16'hA5A5};
    vecs[6]  = '{0, 1'b1, 12'hFFF, 16'h1234, 16'h1234};
    vecs[7]  = '{0, 1'b0, 12'hFFF, 16'h0000, 16'h1234};
    vecs[8]  = '{0, 1'b1, 12'h000, 16'hCAFE, 16'hCAFE};
    vecs[9]  = '{0, 1'b0, 12'hFFF, 16'h0000, 16'h1234};
    vecs[10] = '{3, 1'b1, 12'h010, 16'h0000, 16'h0000};
    vecs[11] = '{3, 1'b0, 12'h010, 16'h0000, 16'h0000};
    vecs[12] = '{2, 1'b1, 12'h100, 16'h1111, 16'h1111};
    vecs[13] = '{2, 1'b1, 12'h101, 16'h2222, 16'h2222};
    vecs[14] = '{2, 1'b1, 12'h102, 16'h3333, 16'h3333};
    vecs[15] = '{2, 1'b1, 12'h103, 16'h4444, 16'h4444};
    tp_addr  = '{12'h100, 12'h101, 12'h102, 12'h103};
    tp_data  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    for (int d = 0; d < NDUT; d++) begin
      rst_n[d]     = 1'b0;
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      rsp_ready[d] = 1'b0;
    end

    // Reset state
    #2;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("rst_req_ready_dut%0d", d), 32'(req_ready[d]), 32'd0);
      chk($sformatf("rst_rsp_valid_dut%0d", d), 32'(rsp_valid[d]), 32'd0);
      chk($sformatf("rst_rsp_rdata_dut%0d", d), 32'(rsp_rdata[d]), 32'd0);
      chk($sformatf("rst_busy_dut%0d", d), 32'(busy[d]), 32'd0);
    end
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) rst_n[d] = 1'b1;
    #1;
    chk("release_ready_before_edge", 32'(req_ready[0]), 32'd0);
    @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++)
      chk($sformatf("release_ready_after_edge_dut%0d", d), 32'(req_ready[d]), 32'd1);

    // Directed vectors
    for (int i = 0; i < 16; i++)
      txn(vecs[i].dut, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp,
          $sformatf("vec%0d", i));

    // Backpressure on the WAIT_CYCLES=1 instance
    rsp_ready[1] = 1'b0;
    issue(1, 1'b0, 12'h0A5, 16'h0000, ok_v);
    wait_rsp(1, lat_v, ok_v);
    chk("bp_latency", 32'(lat_v), 32'd1);
    chk("bp_rdata", 32'(rsp_rdata[1]), 32'hBEEF);
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_addr[1]  = 12'h0A5;
    req_wdata[1] = 16'h0BAD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_valid_%0d", i), 32'(rsp_valid[1]), 32'd1);
      chk($sformatf("bp_hold_rdata_%0d", i), 32'(rsp_rdata[1]), 32'hBEEF);
      chk($sformatf("bp_hold_ready_%0d", i), 32'(req_ready[1]), 32'd0);
    end
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_hs_valid", 32'(rsp_valid[1]), 32'd0);
    chk("bp_hs_ready", 32'(req_ready[1]), 32'd1);
    chk("bp_hs_busy", 32'(busy[1]), 32'd0);
    txn(1, 1'b0, 12'h0A5, 16'h0000, 16'hBEEF, "bp_reread");

    // Asynchronous reset mid-cycle while a response is pending
    rsp_ready[1] = 1'b0;
    issue(1, 1'b0, 12'h0A5, 16'h0000, ok_v);
    wait_rsp(1, lat_v, ok_v);
    @(negedge clk);
    #2;
    rst_n[1] = 1'b0;
    #1;
    chk("async_rst_req_ready", 32'(req_ready[1]), 32'd0);
    chk("async_rst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("async_rst_rsp_rdata", 32'(rsp_rdata[1]), 32'd0);
    chk("async_rst_busy", 32'(busy[1]), 32'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    #1;
    chk("async_rel_ready_before_edge", 32'(req_ready[1]), 32'd0);
    @(posedge clk);
    #1;
    chk("async_rel_ready_after_edge", 32'(req_ready[1]), 32'd1);

    // Reset before the write commits (WAIT_CYCLES=3)
    rsp_ready[3] = 1'b1;
    issue(3, 1'b1, 12'h010, 16'h5555, ok_v);
    @(negedge clk);
    rst_n[3] = 1'b0;
    #1;
    chk("pre_commit_rst_busy", 32'(busy[3]), 32'd0);
    @(negedge clk);
    rst_n[3] = 1'b1;
    txn(3, 1'b0, 12'h010, 16'h0000, 16'h0000, "rst_pre_commit");

    // Reset after the write commits
    rsp_ready[3] = 1'b0;
    issue(3, 1'b1, 12'h010, 16'h5555, ok_v);
    wait_rsp(3, lat_v, ok_v);
    chk("post_commit_latency", 32'(lat_v), 32'd3);
    @(negedge clk);
    rst_n[3] = 1'b0;
    #1;
    chk("post_commit_rst_valid", 32'(rsp_valid[3]), 32'd0);
    @(negedge clk);
    rst_n[3] = 1'b1;
    txn(3, 1'b0, 12'h010, 16'h0000, 16'h5555, "rst_post_commit");

    // Throughput (WAIT_CYCLES=2), req_valid and rsp_ready held high
    nacc = 0;
    nrsp = 0;
    edge_n = 0;
    rsp_ready[2] = 1'b1;
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b0;
    req_addr[2]  = tp_addr[0];
    for (int c = 0; c < 80 && nrsp < 4; c++) begin
      rr = req_ready[2] && req_valid[2];
      if (rsp_valid[2] === 1'b1) begin
        chk($sformatf("tp_rdata_%0d", nrsp), 32'(rsp_rdata[2]), 32'(tp_data[nrsp]));
        nrsp++;
      end
      @(posedge clk);
      edge_n++;
      if (rr) begin
        acc_e[nacc] = edge_n;
        nacc++;
        #1;
        if (nacc < 4) req_addr[2] = tp_addr[nacc];
        else req_valid[2] = 1'b0;
      end
      @(negedge clk);
    end
    req_valid[2] = 1'b0;
    chk("tp_accept_count", 32'(nacc), 32'd4);
    chk("tp_response_count", 32'(nrsp), 32'd4);
    for (int i = 1; i < 4 && i < nacc; i++)
      chk($sformatf("tp_spacing_%0d", i), 32'(acc_e[i] - acc_e[i-1]), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
